// File: rtl/i2s_rx.sv
// I2S master receiver: generates SCK/WS, deserializes one channel of a MEMS
// microphone stream and pushes sign-extended samples into a FIFO write port.
module i2s_rx #(
    parameter int CLK_DIV        = 16,
    parameter int DATA_WIDTH     = 24,
    parameter int OUT_WIDTH      = 32,
    parameter bit CHANNEL        = 1'b0,
    parameter int STARTUP_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    output logic                 i2s_sck_o,
    output logic                 i2s_ws_o,
    input  logic                 i2s_sd_i,
    input  logic                 full_i,
    output logic                 wr_en_o,
    output logic [OUT_WIDTH-1:0] write_data_o,
    output logic                 overflow_o
);

    localparam int DIVW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam int FW   = (STARTUP_FRAMES < 1) ? 1 : $clog2(STARTUP_FRAMES + 1);

    logic                  sd_meta_q, sd_meta_d;
    logic                  sd_sync_q, sd_sync_d;
    logic [DIVW-1:0]       div_q, div_d;
    logic                  sck_q, sck_d;
    logic                  ws_q, ws_d;
    logic [4:0]            bit_q, bit_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  pend_q, pend_d;
    logic                  wr_en_q, wr_en_d;
    logic [OUT_WIDTH-1:0]  data_q, data_d;
    logic                  ovf_q, ovf_d;

    logic                  tick;
    logic                  rise;
    logic                  fall;
    logic                  started;
    logic [DATA_WIDTH:0]   shift_ext;

    assign tick      = (div_q == DIVW'(CLK_DIV - 1));
    assign rise      = tick && !sck_q;
    assign fall      = tick && sck_q;
    // Frame counter saturates at STARTUP_FRAMES, so equality means "settled".
    assign started   = (frame_q == FW'(STARTUP_FRAMES));
    assign shift_ext = {shift_q, sd_sync_q};

    // Next-state logic: divider, bit/frame counters, capture and push.
    always_comb begin
        sd_meta_d = sd_meta_q;
        sd_sync_d = sd_sync_q;
        div_d     = div_q;
        sck_d     = sck_q;
        ws_d      = ws_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        shift_d   = shift_q;
        pend_d    = 1'b0;
        wr_en_d   = 1'b0;
        data_d    = data_q;
        ovf_d     = ovf_q;

        if (!enable_i) begin
            // Idle looks like reset except the sticky overflow flag.
            sd_meta_d = 1'b0;
            sd_sync_d = 1'b0;
            div_d     = '0;
            sck_d     = 1'b0;
            ws_d      = 1'b0;
            bit_d     = '0;
            frame_d   = '0;
            shift_d   = '0;
            data_d    = '0;
        end else begin
            sd_meta_d = i2s_sd_i;
            sd_sync_d = sd_meta_q;
            div_d     = tick ? '0 : div_q + 1'b1;
            if (tick)
                sck_d = ~sck_q;

            // Position 0 is the I2S delay bit; bits past DATA_WIDTH are padding.
            if (rise && (ws_q == CHANNEL) && (bit_q != 5'd0) &&
                (bit_q <= 5'(DATA_WIDTH))) begin
                shift_d = shift_ext[DATA_WIDTH-1:0];
                if (bit_q == 5'(DATA_WIDTH))
                    pend_d = 1'b1;
            end

            if (fall) begin
                bit_d = bit_q + 5'd1;
                if (bit_q == 5'd31) begin
                    ws_d = ~ws_q;
                    if (ws_q && !started)
                        frame_d = frame_q + 1'b1;
                end
            end

            // Word completed last cycle: push it or record the drop.
            if (pend_q && started) begin
                if (!full_i) begin
                    wr_en_d = 1'b1;
                    data_d  = OUT_WIDTH'(signed'(shift_q));
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sd_meta_q <= 1'b0;
            sd_sync_q <= 1'b0;
            div_q     <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            bit_q     <= '0;
            frame_q   <= '0;
            shift_q   <= '0;
            pend_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sd_meta_q <= sd_meta_d;
            sd_sync_q <= sd_sync_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            ws_q      <= ws_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            shift_q   <= shift_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign i2s_sck_o    = sck_q;
    assign i2s_ws_o     = ws_q;
    assign wr_en_o      = wr_en_q;
    assign write_data_o = data_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: left/right capture, startup discard, overflow,
// clocking and reset behaviour, using a behavioural microphone model.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        sd = 1'b1;
    logic        full0 = 1'b0;
    logic        full1 = 1'b0;
    logic        full2 = 1'b0;

    logic        sck0, ws0, wr0, ovf0;
    logic [31:0] dat0;
    logic        sck1, ws1, wr1, ovf1;
    logic [31:0] dat1;
    logic        sck2, ws2, wr2, ovf2;
    logic [31:0] dat2;

    int total = 0;
    int bad   = 0;

    localparam logic [23:0] LWORD = 24'hA5C3F1;
    localparam logic [23:0] RWORD = 24'h123456;
    localparam logic [31:0] LEXP  = 32'hFFA5C3F1;
    localparam logic [31:0] REXP  = 32'h00123456;

    always #5 clk = ~clk;

    i2s_rx #(.CLK_DIV(4), .DATA_WIDTH(24), .OUT_WIDTH(32), .CHANNEL(1'b0), .STARTUP_FRAMES(0)) u_left (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .i2s_sck_o(sck0), .i2s_ws_o(ws0),
        .i2s_sd_i(sd), .full_i(full0), .wr_en_o(wr0), .write_data_o(dat0), .overflow_o(ovf0));

    i2s_rx #(.CLK_DIV(4), .DATA_WIDTH(24), .OUT_WIDTH(32), .CHANNEL(1'b1), .STARTUP_FRAMES(0)) u_right (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .i2s_sck_o(sck1), .i2s_ws_o(ws1),
        .i2s_sd_i(sd), .full_i(full1), .wr_en_o(wr1), .write_data_o(dat1), .overflow_o(ovf1));

    i2s_rx #(.CLK_DIV(4), .DATA_WIDTH(24), .OUT_WIDTH(32), .CHANNEL(1'b0), .STARTUP_FRAMES(2)) u_start (
        .clk(clk), .rst_n(rst_n), .enable_i(enable), .i2s_sck_o(sck2), .i2s_ws_o(ws2),
        .i2s_sd_i(sd), .full_i(full2), .wr_en_o(wr2), .write_data_o(dat2), .overflow_o(ovf2));

    // Microphone model: new bit after each SCK fall, position counted from WS edges.
    // Ignored positions (delay bit, padding) are driven high so a wrong capture shows.
    int          mpos = 0;
    logic        mprev = 1'b0;
    logic        mpsck = 1'b0;
    logic [23:0] mword;
    always @(posedge clk) begin
        #2;
        if (!enable || !rst_n) begin
            mpos  = 0;
            mprev = 1'b0;
            sd    = 1'b1;
        end else if (mpsck && !sck0) begin
            if (ws0 != mprev) mpos = 0;
            else              mpos = mpos + 1;
            mprev = ws0;
            mword = ws0 ? RWORD : LWORD;
            if (mpos >= 1 && mpos <= 24) sd = mword[24-mpos];
            else                         sd = 1'b1;
        end
        mpsck = sck0;
    end

    // Observation state shared by the tasks (single process drives it).
    int          cyc;
    int          s0c[$];
    logic [31:0] s0d[$];
    int          s1c[$];
    logic [31:0] s1d[$];
    int          s2c[$];
    int          rise_c[$];
    int          wsch_c[$];
    int          ws_bad;
    logic        psck, pws;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
            if (wr0) begin s0c.push_back(cyc); s0d.push_back(dat0); end
            if (wr1) begin s1c.push_back(cyc); s1d.push_back(dat1); end
            if (wr2) s2c.push_back(cyc);
            if (sck0 && !psck) rise_c.push_back(cyc);
            if (ws0 != pws) begin
                wsch_c.push_back(cyc);
                if (!(psck && !sck0)) ws_bad++;
            end
            psck = sck0;
            pws  = ws0;
        end
    endtask

    task automatic clear_obs();
        s0c.delete(); s0d.delete(); s1c.delete(); s1d.delete(); s2c.delete();
        rise_c.delete(); wsch_c.delete();
        ws_bad = 0;
        cyc    = 0;
        psck   = sck0;
        pws    = ws0;
    endtask

    // Disable for a few cycles, then raise enable so the next posedge is cycle 0's end.
    task automatic start();
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        clear_obs();
        enable = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        step(100);
        total++; if (rise_c.size() !== 0) begin bad++; $display("FAIL reset_sck_static: rises=%0d want 0", rise_c.size()); end
        total++; if (sck0 !== 1'b0) begin bad++; $display("FAIL reset_sck: got %b want 0", sck0); end
        total++; if (ws0 !== 1'b0) begin bad++; $display("FAIL reset_ws: got %b want 0", ws0); end
        total++; if (s0c.size() + s1c.size() + s2c.size() !== 0) begin bad++; $display("FAIL reset_wr_en: pushes=%0d want 0", s0c.size() + s1c.size() + s2c.size()); end
        total++; if (dat0 !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", dat0); end
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", ovf0); end
    endtask

    task automatic test_clocking();
        start();
        step(600);
        total++; if (rise_c.size() < 2) begin bad++; $display("FAIL clk_rises: got %0d rises want >=2", rise_c.size()); end
        else begin
            total++; if (rise_c[0] !== 4) begin bad++; $display("FAIL clk_first_rise: got cycle %0d want 4", rise_c[0]); end
            total++; if (rise_c[1] - rise_c[0] !== 8) begin bad++; $display("FAIL clk_period: got %0d want 8", rise_c[1] - rise_c[0]); end
        end
        total++; if (wsch_c.size() !== 2) begin bad++; $display("FAIL ws_toggles: got %0d want 2", wsch_c.size()); end
        else begin
            total++; if (wsch_c[0] !== 256) begin bad++; $display("FAIL ws_first: got cycle %0d want 256", wsch_c[0]); end
            total++; if (wsch_c[1] !== 512) begin bad++; $display("FAIL ws_second: got cycle %0d want 512", wsch_c[1]); end
        end
        total++; if (ws_bad !== 0) begin bad++; $display("FAIL ws_on_sck_fall: stray toggles=%0d want 0", ws_bad); end
    endtask

    task automatic test_left_capture();
        start();
        step(1300);
        total++; if (s0c.size() !== 3) begin bad++; $display("FAIL left_count: got %0d want 3", s0c.size()); end
        else begin
            total++; if (s0c[0] !== 197) begin bad++; $display("FAIL left_first_cycle: got %0d want 197", s0c[0]); end
            total++; if (s0c[1] !== 709 || s0c[2] !== 1221) begin bad++; $display("FAIL left_per_frame: got %0d,%0d want 709,1221", s0c[1], s0c[2]); end
            for (int i = 0; i < 3; i++) begin
                total++; if (s0d[i] !== LEXP) begin bad++; $display("FAIL left_data[%0d]: got %h want %h", i, s0d[i], LEXP); end
            end
        end
    endtask

    task automatic test_right_capture();
        start();
        step(1000);
        total++; if (s1c.size() !== 2) begin bad++; $display("FAIL right_count: got %0d want 2", s1c.size()); end
        else begin
            total++; if (s1c[0] !== 453 || s1c[1] !== 965) begin bad++; $display("FAIL right_cycles: got %0d,%0d want 453,965", s1c[0], s1c[1]); end
            for (int i = 0; i < 2; i++) begin
                total++; if (s1d[i] !== REXP) begin bad++; $display("FAIL right_data[%0d]: got %h want %h", i, s1d[i], REXP); end
            end
        end
    endtask

    task automatic test_startup();
        start();
        step(1800);
        total++; if (s2c.size() !== 2) begin bad++; $display("FAIL startup_count: got %0d want 2", s2c.size()); end
        else begin
            total++; if (s2c[0] !== 1221) begin bad++; $display("FAIL startup_first: got cycle %0d want 1221", s2c[0]); end
            total++; if (s2c[1] !== 1733) begin bad++; $display("FAIL startup_second: got cycle %0d want 1733", s2c[1]); end
        end
        total++; if (dat2 !== LEXP) begin bad++; $display("FAIL startup_data: got %h want %h", dat2, LEXP); end
    endtask

    task automatic test_overflow();
        full0 = 1'b1;
        start();
        step(300);
        total++; if (s0c.size() !== 0) begin bad++; $display("FAIL ovf_no_strobe: pushes=%0d want 0", s0c.size()); end
        total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf0); end
        @(negedge clk);
        full0 = 1'b0;
        step(500);
        total++; if (s0c.size() !== 1) begin bad++; $display("FAIL ovf_recover_count: got %0d want 1", s0c.size()); end
        else begin
            total++; if (s0c[0] !== 709 || s0d[0] !== LEXP) begin bad++; $display("FAIL ovf_recover: got cycle %0d data %h want 709 %h", s0c[0], s0d[0], LEXP); end
        end
        total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", ovf0); end
        @(negedge clk);
        enable = 1'b0;
        step(5);
        total++; if (ovf0 !== 1'b1 || dat0 !== 32'h0) begin bad++; $display("FAIL ovf_hold_on_disable: got ovf=%b data=%h want 1 0", ovf0, dat0); end
        @(negedge clk);
        rst_n = 1'b0;
        step(1);
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL ovf_reset_clear: got %b want 0", ovf0); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        start();
        step(690);
        total++; if (dat0 !== LEXP) begin bad++; $display("FAIL mid_pre_data: got %h want %h", dat0, LEXP); end
        rst_n = 1'b0;
        step(1);
        total++; if ({sck0, ws0, wr0, ovf0} !== 4'b0 || dat0 !== 32'h0) begin
            bad++; $display("FAIL mid_reset_outputs: got sck=%b ws=%b wr=%b ovf=%b data=%h want all 0", sck0, ws0, wr0, ovf0, dat0);
        end
        #5;
        rst_n = 1'b1;
        step(100);
        total++; if (s0c.size() !== 1) begin bad++; $display("FAIL mid_no_push: got %0d pushes want 1 (pre-reset only)", s0c.size()); end
    endtask

    initial begin
        test_reset();
        test_clocking();
        test_left_capture();
        test_right_capture();
        test_startup();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
